// File: rtl/lms_pkg.sv
// Shared types, default parameters and saturation helper for the LMS filter core.
package lms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    ERR,
    UPD,
    DONE
  } state_e;

  localparam int DEF_TAPS      = 16;
  localparam int DEF_DATA_W    = 14;
  localparam int DEF_COEF_W    = 32;
  localparam int DEF_FRAC_BITS = 16;
  localparam int DEF_MU_SHIFT  = 8;

  // Working width for saturation; wide enough for any intermediate in the core.
  localparam int SAT_W = 128;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/lms_delay_line.sv
// Reference-sample delay line: tap 0 holds the newest sample, one read port by index.
module lms_delay_line #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [$clog2(TAPS)-1:0]  rd_idx,
  output logic signed [DATA_W-1:0] x_rd
);

  logic signed [DATA_W-1:0] tap_q [TAPS];
  logic signed [DATA_W-1:0] tap_d [TAPS];

  // Shift the new sample in at tap 0; the oldest sample falls off the end.
  always_comb begin
    tap_d = tap_q;
    if (shift_en) begin
      tap_d[0] = x_in;
      for (int k = 1; k < TAPS; k++) begin
        tap_d[k] = tap_q[k-1];
      end
    end
  end

  // Tap registers, cleared by reset so a fresh run starts from silence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      tap_q <= tap_d;
    end
  end

  assign x_rd = tap_q[rd_idx];

endmodule

// File: rtl/lms_filter_core.sv
// Time-multiplexed LMS adaptive FIR: one multiplier serves the MAC pass and the update pass.
module lms_filter_core
  import lms_pkg::*;
#(
  parameter int TAPS      = DEF_TAPS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int MU_SHIFT  = DEF_MU_SHIFT,
  parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] d_in,
  input  logic                     adapt_en,
  input  logic                     coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]  coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] e_out,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [SAT_W-1:0] v);
    return DATA_W'(sat(v, DATA_W));
  endfunction

  function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [SAT_W-1:0] v);
    return COEF_W'(sat(v, COEF_W));
  endfunction

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] dsr_q, dsr_d;
  logic                     adapt_q, adapt_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic signed [DATA_W-1:0] e_q, e_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [COEF_W-1:0] w_q [TAPS];
  logic signed [COEF_W-1:0] w_d [TAPS];

  logic                     shift_en;
  logic signed [DATA_W-1:0] x_rd;
  logic signed [COEF_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [DATA_W-1:0] y_new;

  assign in_ready  = (state_q == IDLE) && !coef_wr_en;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign e_out     = e_q;

  lms_delay_line #(
    .TAPS  (TAPS),
    .DATA_W(DATA_W)
  ) u_dline (
    .clk     (clk),
    .rst     (rst),
    .shift_en(shift_en),
    .x_in    (x_in),
    .rd_idx  (idx_q),
    .x_rd    (x_rd)
  );

  // Shared multiplier: x[k] times w[k] while filtering, x[k] times e while adapting.
  always_comb begin
    mul_b = (state_q == UPD) ? COEF_W'(e_q) : w_q[idx_q];
    prod  = PROD_W'(x_rd) * PROD_W'(mul_b);
  end

  // Next-state, accumulator, result and coefficient update logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    dsr_d       = dsr_q;
    adapt_d     = adapt_q;
    y_d         = y_q;
    e_d         = e_q;
    out_valid_d = 1'b0;
    w_d         = w_q;
    shift_en    = 1'b0;
    acc_shift   = acc_q >>> FRAC_BITS;
    y_new       = sat_data(SAT_W'(acc_shift));
    case (state_q)
      IDLE: begin
        // Writes only land while idle; an out-of-range index is dropped.
        if (coef_wr_en && (int'(coef_wr_addr) < TAPS)) begin
          w_d[coef_wr_addr] = coef_wr_data;
        end
        if (in_valid && in_ready) begin
          shift_en = 1'b1;
          dsr_d    = d_in;
          adapt_d  = adapt_en;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ERR;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ERR: begin
        // Error is formed from the already-saturated output, then saturated itself.
        y_d     = y_new;
        e_d     = sat_data(SAT_W'(dsr_q) - SAT_W'(y_new));
        state_d = adapt_q ? UPD : DONE;
      end
      UPD: begin
        w_d[idx_q] = sat_coef(SAT_W'(w_q[idx_q]) + (SAT_W'(prod) >>> MU_SHIFT));
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, result and coefficient registers; reset aborts any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      adapt_q     <= 1'b0;
      y_q         <= '0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      adapt_q     <= adapt_d;
      y_q         <= y_d;
      e_q         <= e_d;
      out_valid_q <= out_valid_d;
      w_q         <= w_d;
    end
  end

  // Accumulator and captured desired sample; both are reloaded on every accept.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    dsr_q <= dsr_d;
  end

endmodule

// File: tb/tb_lms_filter_core.sv
// Scoreboard bench for lms_filter_core: directed samples with hand-computed results.
module tb_lms_filter_core;

  localparam int TAPS   = 16;
  localparam int DATA_W = 14;
  localparam int COEF_W = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] d_in = '0;
  logic                     adapt_en = 1'b0;
  logic                     coef_wr_en = 1'b0;
  logic [3:0]               coef_wr_addr = '0;
  logic signed [COEF_W-1:0] coef_wr_data = '0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] y_out;
  logic signed [DATA_W-1:0] e_out;
  logic                     busy;

  lms_filter_core dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_in        (x_in),
    .d_in        (d_in),
    .adapt_en    (adapt_en),
    .coef_wr_en  (coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .out_valid   (out_valid),
    .y_out       (y_out),
    .e_out       (e_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int y;
    int e;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t ex;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        ex = sb_q.pop_front();
        chk("y_out", y_out, ex.y);
        chk("e_out", e_out, ex.e);
        chk("latency", cyc, ex.cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_coef(input int addr, input longint data);
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'(addr);
    coef_wr_data = 32'(data);
    @(negedge clk);
    coef_wr_en   = 1'b0;
  endtask

  task automatic send(input int x, input int d, input bit ad, input bit want,
                      input int ey, input int ee);
    exp_t ex;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected 1");
      return;
    end
    x_in     = DATA_W'(x);
    d_in     = DATA_W'(d);
    adapt_en = ad;
    in_valid = 1'b1;
    if (want) begin
      ex.y   = ey;
      ex.e   = ee;
      ex.cyc = cyc + 1 + (ad ? 2 * TAPS + 2 : TAPS + 2);
      sb_q.push_back(ex);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish by 400000, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y_out", y_out, 0);
    chk("rst_e_out", e_out, 0);

    // Identity tap, no adaptation.
    wr_coef(0, 65536);
    send(100, 150, 1'b0, 1'b1, 100, 50);
    drain();
    chk("ident_w0", dut.w_q[0], 65536);
    chk("ident_w1", dut.w_q[1], 0);

    // Identity tap with one adaptation step: 50*100 >>> 8 = 19.
    do_reset();
    wr_coef(0, 65536);
    send(100, 150, 1'b1, 1'b1, 100, 50);
    drain();
    chk("adapt_w0", dut.w_q[0], 65555);
    chk("adapt_w1", dut.w_q[1], 0);
    chk("adapt_w15", dut.w_q[15], 0);

    // Delay line: a tap at index 3 reproduces the sample three inputs later.
    do_reset();
    wr_coef(3, 65536);
    send(7, 0, 1'b0, 1'b1, 0, 0);
    send(0, 0, 1'b0, 1'b1, 0, 0);
    send(0, 0, 1'b0, 1'b1, 0, 0);
    send(0, 0, 1'b0, 1'b1, 7, -7);
    drain();

    // Negative coefficient.
    do_reset();
    wr_coef(0, -65536);
    send(100, 0, 1'b0, 1'b1, -100, 100);
    drain();

    // Output and error saturation.
    do_reset();
    wr_coef(0, 64'h7FFF_FFFF);
    send(8191, -8192, 1'b0, 1'b1, 8191, -8192);
    drain();

    // Coefficient clamp: w0 would exceed the maximum, w1 moves down by 262112.
    do_reset();
    wr_coef(0, 64'h7FFF_FFFF);
    wr_coef(1, 64'h7FFF_FFFF);
    send(-8192, 0, 1'b0, 1'b1, -8192, 8191);
    send(8191, 8191, 1'b1, 1'b1, -8192, 8191);
    drain();
    chk("clamp_w0", dut.w_q[0], 64'sd2147483647);
    chk("clamp_w1", dut.w_q[1], 64'sd2147221535);
    chk("clamp_w2", dut.w_q[2], 0);

    // Write alongside in_valid: write first, sample on the following edge.
    do_reset();
    @(negedge clk);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'd0;
    coef_wr_data = 32'sd65536;
    x_in         = 14'sd100;
    d_in         = 14'sd150;
    adapt_en     = 1'b0;
    in_valid     = 1'b1;
    #1;
    chk("wr_blocks_in_ready", in_ready, 0);
    @(negedge clk);
    coef_wr_en = 1'b0;
    #1;
    chk("in_ready_after_wr", in_ready, 1);
    begin
      exp_t ex;
      ex.y   = 100;
      ex.e   = 50;
      ex.cyc = cyc + 1 + TAPS + 2;
      sb_q.push_back(ex);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // A write attempted during MAC is ignored.
    send(100, 150, 1'b0, 1'b1, 100, 50);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 4'd0;
    coef_wr_data = '0;
    #1;
    chk("mac_busy", busy, 1);
    chk("mac_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    coef_wr_en = 1'b0;
    drain();
    chk("mac_wr_ignored_w0", dut.w_q[0], 65536);

    // Reset during UPD: no result, coefficients cleared, outputs back to zero.
    send(100, 150, 1'b1, 1'b0, 0, 0);
    repeat (TAPS + 4) @(negedge clk);
    chk("upd_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_y_out", y_out, 0);
    chk("abort_e_out", e_out, 0);
    chk("abort_w0", dut.w_q[0], 0);
    repeat (2 * TAPS + 4) @(negedge clk);
    send(5, 0, 1'b0, 1'b1, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
